// File: rtl/md5_pkg.sv
// Shared MD5 definitions: block geometry, byte/block types and MD5 message padding.
package md5_pkg;

    localparam int BLOCK_WIDTH   = 512;
    localparam int DIGEST_WIDTH  = 128;
    localparam int MSG_MAX_BYTES = 16;

    typedef logic [7:0]             byte_t;
    typedef logic [BLOCK_WIDTH-1:0] md5_block_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // msg is left-justified (byte 0 in the MSBs); bytes at or beyond len are ignored.
    function automatic md5_block_t pad_block(input logic [MSG_MAX_BYTES*8-1:0] msg,
                                             input byte_t                      len);
        md5_block_t  blk;
        logic [63:0] bit_count;
        blk = '0;
        for (int i = 0; i < MSG_MAX_BYTES; i++) begin
            if (8'(i) < len) begin
                blk[BLOCK_WIDTH-1-8*i -: 8] = msg[MSG_MAX_BYTES*8-1-8*i -: 8];
            end else if (8'(i) == len) begin
                blk[BLOCK_WIDTH-1-8*i -: 8] = 8'h80;
            end
        end
        if (len == 8'(MSG_MAX_BYTES)) begin
            blk[BLOCK_WIDTH-1-8*MSG_MAX_BYTES -: 8] = 8'h80;
        end
        // Length field is little-endian in bytes 56..63.
        bit_count = {53'd0, len, 3'd0};
        for (int i = 0; i < 8; i++) begin
            blk[BLOCK_WIDTH-1-8*(56+i) -: 8] = bit_count[8*i +: 8];
        end
        return blk;
    endfunction

endpackage

// File: rtl/md5_block_builder_bcd_counter.sv
// Decimal counter of DIGITS BCD digits plus a used-digit count, no leading zeros.
// Outputs show the value held after the current edge, so a consumer can register it in step.
module bcd_counter #(
    parameter int DIGITS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        incr,
    output logic [DIGITS*4-1:0]         digits,
    output logic [$clog2(DIGITS+1)-1:0] digit_count,
    output logic                        carry_out
);
    localparam int            CW        = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DIGITS);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);

    logic [DIGITS*4-1:0] digits_q, digits_d;
    logic [CW-1:0]       count_q, count_d;
    logic                all_nines;
    logic                ripple;

    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            count_q  <= COUNT_ONE;
        end else begin
            digits_q <= digits_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (CW'(i) < count_q && digits_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
        end
    end

    always_comb begin
        digits_d  = digits_q;
        count_d   = count_q;
        carry_out = 1'b0;
        ripple    = 1'b0;
        if (clear) begin
            digits_d      = '0;
            digits_d[3:0] = 4'd1;
            count_d       = COUNT_ONE;
        end else if (incr) begin
            ripple = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (ripple) begin
                    if (digits_q[4*i +: 4] == 4'd9) begin
                        digits_d[4*i +: 4] = 4'd0;
                    end else begin
                        digits_d[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                        ripple             = 1'b0;
                    end
                end
            end
            // Digits above the count are zero, so an all-nines value grows by one digit.
            if (all_nines) begin
                if (count_q == COUNT_MAX) carry_out = 1'b1;
                else                      count_d   = count_q + COUNT_ONE;
            end
        end
    end

    assign digits      = digits_d;
    assign digit_count = count_d;

endmodule

// File: rtl/md5_block_builder.sv
// Builds padded MD5 blocks for "<key><N>", N = 1, 2, ... and streams them to the engine.
//   state   | meaning
//   IDLE    | after reset, waiting for a key
//   RUN     | block for current N presented, valid high
//   HALT    | stopped on a filter hit or counter overflow; a new key restarts
module md5_block_builder #(
    parameter int BLOCK_WIDTH   = 512,
    parameter int KEY_MAX_BYTES = 8,
    parameter int DIGITS_MAX    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               key_valid,
    input  logic [KEY_MAX_BYTES*8-1:0]         key_data,
    input  logic [$clog2(KEY_MAX_BYTES+1)-1:0] key_length,
    input  logic                               stop,
    input  logic                               md5_block_ready,
    output logic                               md5_block_valid,
    output logic [BLOCK_WIDTH-1:0]             md5_block_data,
    output logic                               busy,
    output logic                               overflow
);
    localparam int KLW      = $clog2(KEY_MAX_BYTES + 1);
    localparam int CW       = $clog2(DIGITS_MAX + 1);
    localparam int MSG_BITS = md5_pkg::MSG_MAX_BYTES * 8;
    localparam int KEY_BITS = KEY_MAX_BYTES * 8;

    if (BLOCK_WIDTH != md5_pkg::BLOCK_WIDTH) begin : g_bad_width
        $error("md5_block_builder: BLOCK_WIDTH must be 512");
    end
    if (KEY_MAX_BYTES + DIGITS_MAX > md5_pkg::MSG_MAX_BYTES) begin : g_bad_msg
        $error("md5_block_builder: KEY_MAX_BYTES + DIGITS_MAX must not exceed 16");
    end

    md5_pkg::state_t        state_q, state_d;
    logic [KEY_BITS-1:0]    key_q, key_d;
    logic [KLW-1:0]         key_len_q, key_len_d;
    logic [BLOCK_WIDTH-1:0] block_q, block_d;
    logic                   overflow_q, overflow_d;

    logic                   key_ok, load, handshake;
    logic [DIGITS_MAX*4-1:0] cnt_digits;
    logic [CW-1:0]          cnt_count;
    logic                   cnt_carry;
    logic [KEY_BITS-1:0]    key_sel;
    logic [KLW-1:0]         key_len_sel;
    logic [MSG_BITS-1:0]    key_wide, msg;
    md5_pkg::byte_t         msg_len;
    logic [BLOCK_WIDTH-1:0] block_next;

    assign key_ok    = (key_length != '0) && (key_length <= KLW'(KEY_MAX_BYTES));
    assign load      = key_valid && key_ok && (state_q != md5_pkg::ST_RUN);
    assign handshake = (state_q == md5_pkg::ST_RUN) && md5_block_ready;

    bcd_counter #(.DIGITS(DIGITS_MAX)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (load),
        .incr       (handshake),
        .digits     (cnt_digits),
        .digit_count(cnt_count),
        .carry_out  (cnt_carry)
    );

    // On a load the key comes straight from the ports, since key_q updates on the same edge.
    always_comb begin : msg_build
        int klen;
        int dcnt;
        key_sel     = load ? key_data : key_q;
        key_len_sel = load ? key_length : key_len_q;
        key_wide    = {key_sel, {(MSG_BITS-KEY_BITS){1'b0}}};
        klen        = int'(key_len_sel);
        dcnt        = int'(cnt_count);
        msg         = '0;
        for (int j = 0; j < md5_pkg::MSG_MAX_BYTES; j++) begin
            if (j < klen) begin
                msg[MSG_BITS-1-8*j -: 8] = key_wide[MSG_BITS-1-8*j -: 8];
            end else if (j < klen + dcnt) begin
                msg[MSG_BITS-1-8*j -: 8] = {4'h3, cnt_digits[4*(dcnt-1-(j-klen)) +: 4]};
            end
        end
        msg_len = 8'(klen + dcnt);
    end

    assign block_next = md5_pkg::pad_block(msg, msg_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= md5_pkg::ST_IDLE;
            key_q      <= '0;
            key_len_q  <= '0;
            block_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            key_len_q  <= key_len_d;
            block_q    <= block_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        key_d      = key_q;
        key_len_d  = key_len_q;
        block_d    = block_q;
        overflow_d = overflow_q;
        case (state_q)
            md5_pkg::ST_IDLE, md5_pkg::ST_HALT: begin
                if (load) begin
                    state_d    = md5_pkg::ST_RUN;
                    key_d      = key_data;
                    key_len_d  = key_length;
                    block_d    = block_next;
                    overflow_d = 1'b0;
                end
            end
            md5_pkg::ST_RUN: begin
                if (handshake && cnt_carry) begin
                    state_d    = md5_pkg::ST_HALT;
                    overflow_d = 1'b1;
                end else begin
                    if (handshake) block_d = block_next;
                    if (stop)      state_d = md5_pkg::ST_HALT;
                end
            end
            default: state_d = md5_pkg::ST_IDLE;
        endcase
    end

    always_comb begin : outputs
        md5_block_valid = (state_q == md5_pkg::ST_RUN);
        busy            = (state_q == md5_pkg::ST_RUN);
        md5_block_data  = block_q;
        overflow        = overflow_q;
    end

endmodule

// File: tb/tb_md5_block_builder.sv
// Directed bench for md5_block_builder with a scoreboard of expected blocks.
module tb_md5_block_builder;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid, key_valid2;
    logic [63:0]  key_data;
    logic [3:0]   key_length;
    logic         stop, stop2, ready, ready2;
    logic         valid, valid2, busy, busy2, ovf, ovf2;
    logic [511:0] data, data2;

    int checks = 0;
    int errors = 0;
    logic [511:0] exp_q[$];

    always #5 clk = ~clk;

    md5_block_builder dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data),
        .key_length(key_length), .stop(stop), .md5_block_ready(ready),
        .md5_block_valid(valid), .md5_block_data(data), .busy(busy), .overflow(ovf)
    );

    md5_block_builder #(.DIGITS_MAX(2)) dut2 (
        .clk(clk), .reset(reset), .key_valid(key_valid2), .key_data(key_data),
        .key_length(key_length), .stop(stop2), .md5_block_ready(ready2),
        .md5_block_valid(valid2), .md5_block_data(data2), .busy(busy2), .overflow(ovf2)
    );

    function automatic logic [511:0] model(input string key, input int n);
        byte unsigned b[64];
        string        s;
        int           l;
        logic [511:0] r;
        s = {key, $sformatf("%0d", n)};
        l = s.len();
        foreach (b[i]) b[i] = 8'h00;
        for (int i = 0; i < l; i++) b[i] = s[i];
        b[l] = 8'h80;
        for (int i = 0; i < 8; i++) b[56+i] = 8'((l * 8) >> (8 * i));
        r = '0;
        for (int i = 0; i < 64; i++) r[511-8*i -: 8] = b[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_key(input string key);
        key_data = '0;
        for (int i = 0; i < key.len(); i++) key_data[63-8*i -: 8] = key[i];
        key_length = 4'(key.len());
    endtask

    // Ready is already high; the coming edge completes a handshake on the presented block.
    task automatic take(input bit second);
        logic [511:0] exp;
        check_bit("hs_valid", second ? valid2 : valid, 1'b1);
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed=0 expected=nonzero");
        end
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check_blk("hs_data", second ? data2 : data, exp);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_valid2 = 1'b0; key_data = '0; key_length = '0;
        stop = 1'b0; stop2 = 1'b0; ready = 1'b0; ready2 = 1'b0;
        repeat (3) tick();
        check_bit("rst_valid", valid, 1'b0);
        check_blk("rst_data", data, '0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_ovf", ovf, 1'b0);
        check_bit("rst_valid2", valid2, 1'b0);
        reset = 1'b0;
        tick();

        // Run A: hold with ready low, then stream through 9 -> 10 and stop on N=12.
        load_key("abcdef"); key_valid = 1'b1;
        exp_q.push_back(model("abcdef", 1));
        tick();
        key_valid = 1'b0;
        check_bit("a_valid", valid, 1'b1);
        check_bit("a_busy", busy, 1'b1);
        repeat (3) begin
            check_blk("a_hold_data", data, exp_q[0]);
            tick();
        end
        check_bit("a_hold_valid", valid, 1'b1);
        ready = 1'b1;
        for (int n = 2; n <= 12; n++) begin
            exp_q.push_back(model("abcdef", n));
            take(1'b0);
        end
        stop = 1'b1;
        take(1'b0);
        stop = 1'b0;
        check_bit("a_stop_valid", valid, 1'b0);
        check_bit("a_stop_busy", busy, 1'b0);
        check_bit("a_stop_ovf", ovf, 1'b0);
        tick();
        check_bit("a_halt_valid", valid, 1'b0);
        check_int("a_sb_drained", exp_q.size(), 0);

        // Run B: restart from HALT, key_valid in RUN ignored, stop with the N=5 handshake.
        load_key("xyz"); key_valid = 1'b1;
        exp_q.push_back(model("xyz", 1));
        tick();
        key_valid = 1'b0;
        for (int n = 2; n <= 5; n++) begin
            exp_q.push_back(model("xyz", n));
            if (n == 3) begin
                load_key("qq"); key_valid = 1'b1;
            end
            take(1'b0);
            key_valid = 1'b0;
        end
        stop = 1'b1;
        take(1'b0);
        stop = 1'b0;
        check_bit("b_stop_valid", valid, 1'b0);
        check_bit("b_stop_busy", busy, 1'b0);
        tick();
        check_bit("b_no_n6_valid", valid, 1'b0);
        check_int("b_sb_drained", exp_q.size(), 0);

        // Run C: two-digit counter runs to 99 and overflows, then a new key restarts it.
        load_key("k"); key_valid2 = 1'b1; ready2 = 1'b1;
        exp_q.push_back(model("k", 1));
        tick();
        key_valid2 = 1'b0;
        for (int n = 2; n <= 99; n++) begin
            exp_q.push_back(model("k", n));
            take(1'b1);
        end
        take(1'b1);
        check_bit("c_ovf", ovf2, 1'b1);
        check_bit("c_ovf_valid", valid2, 1'b0);
        check_bit("c_ovf_busy", busy2, 1'b0);
        tick();
        check_bit("c_halt_valid", valid2, 1'b0);
        check_bit("c_ovf_sticky", ovf2, 1'b1);
        key_valid2 = 1'b1;
        exp_q.push_back(model("k", 1));
        tick();
        key_valid2 = 1'b0;
        check_bit("c_restart_ovf", ovf2, 1'b0);
        check_bit("c_restart_valid", valid2, 1'b1);
        take(1'b1);
        ready2 = 1'b0;

        // Run D: reset mid-run, then out-of-range key lengths are ignored.
        ready = 1'b0;
        load_key("abcdef"); key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check_bit("d_valid", valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_bit("d_rst_valid", valid, 1'b0);
        check_bit("d_rst_busy", busy, 1'b0);
        check_blk("d_rst_data", data, '0);
        key_length = 4'd0; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check_bit("d_len0_valid", valid, 1'b0);
        key_length = 4'd9; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check_bit("d_len9_valid", valid, 1'b0);
        check_bit("d_len9_busy", busy, 1'b0);
        load_key("ab"); key_valid = 1'b1;
        exp_q.push_back(model("ab", 1));
        tick();
        key_valid = 1'b0;
        ready = 1'b1;
        take(1'b0);
        check_int("d_sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
